// File: rtl/ram_responder_pkg.sv
// Shared bus widths, read-latency limit and command decode for the RAM responder.
// The interface, the read pipeline and the responder top all import this package.
package ram_responder_pkg;
  localparam int ADDR_BUS_WIDTH   = 16;
  localparam int DATA_BUS_WIDTH   = 32;
  localparam int RAM_READ_LAT_MAX = 4;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } ram_cmd_e;

  // When W_req and oe are both high, the write wins and no read is issued.
  function automatic ram_cmd_e decode_cmd(input logic cs, input logic oe, input logic w_req);
    ram_cmd_e cmd;
    cmd = CMD_IDLE;
    if (cs && w_req) begin
      cmd = CMD_WRITE;
    end else if (cs && oe) begin
      cmd = CMD_READ;
    end
    return cmd;
  endfunction
endpackage

// File: rtl/ram_intf.sv
// Compute-unit to memory bus. Compute units drive the bus through the master modport,
// and the responder serves it through the memory modport.
interface ram_intf;
  import ram_responder_pkg::*;

  logic                      cs;
  logic                      oe;
  logic [ADDR_BUS_WIDTH-1:0] addr;
  logic                      W_req;
  logic [DATA_BUS_WIDTH-1:0] W_data;
  logic [DATA_BUS_WIDTH-1:0] R_data;

  modport memory (input cs, oe, addr, W_req, W_data, output R_data);
  modport master (output cs, oe, addr, W_req, W_data, input R_data);
endinterface

// File: rtl/ram_responder_rd_pipe.sv
// Valid+data shift pipeline that carries read results from the issue edge to the output.
// Only the valid bits are reset, so reads still in flight when reset arrives are dropped.
module ram_rd_pipe #(
  parameter int STAGES = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;
  logic [DATA_W-1:0] data_d [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      data_q[i] <= data_d[i];
    end
  end

  assign out_vld  = vld_q[STAGES-1];
  assign out_data = data_q[STAGES-1];
endmodule

// File: rtl/ram_responder.sv
// Word-addressed RAM behind a ram_intf memory port, with fixed-latency reads,
// a sticky out-of-range flag and wrapping read/write access counters.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  ram_intf.memory          mem,
  output logic             oob_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BUS_WIDTH:0] DEPTH_L = (ADDR_BUS_WIDTH+1)'(DEPTH);

  if (READ_LAT < 1 || READ_LAT > RAM_READ_LAT_MAX) begin : g_bad_read_lat
    $error("ram_responder: READ_LAT must be within 1..RAM_READ_LAT_MAX");
  end
  if (DEPTH < 1 || DEPTH > (2**ADDR_BUS_WIDTH)) begin : g_bad_depth
    $error("ram_responder: DEPTH must be within 1..2**ADDR_BUS_WIDTH");
  end

  ram_cmd_e                  cmd;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;
  logic                      wr_en;
  logic                      rd_issue;
  logic [DATA_BUS_WIDTH-1:0] rd_word;
  logic                      pipe_vld;
  logic [DATA_BUS_WIDTH-1:0] pipe_data;

  logic [DATA_BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_BUS_WIDTH-1:0] r_data_d, r_data_q;
  logic                      oob_err_d, oob_err_q;
  logic [CNT_W-1:0]          rd_cnt_d, rd_cnt_q;
  logic [CNT_W-1:0]          wr_cnt_d, wr_cnt_q;

  // Out-of-range accesses still count and still issue a read, but that read carries zero.
  always_comb begin
    cmd       = decode_cmd(mem.cs, mem.oe, mem.W_req);
    in_range  = ({1'b0, mem.addr} < DEPTH_L);
    idx       = mem.addr[IDX_W-1:0];
    wr_en     = (cmd == CMD_WRITE) && in_range;
    rd_issue  = (cmd == CMD_READ);
    rd_word   = '0;
    if (rd_issue && in_range) begin
      rd_word = mem_q[idx];
    end
    oob_err_d = oob_err_q | ((cmd != CMD_IDLE) && !in_range);
    rd_cnt_d  = rd_cnt_q + CNT_W'(rd_issue);
    wr_cnt_d  = wr_cnt_q + CNT_W'(cmd == CMD_WRITE);
    r_data_d  = pipe_vld ? pipe_data : r_data_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= mem.W_data;
    end
  end

  ram_rd_pipe #(
    .STAGES (READ_LAT),
    .DATA_W (DATA_BUS_WIDTH)
  ) u_rd_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld   (rd_issue),
    .in_data  (rd_word),
    .out_vld  (pipe_vld),
    .out_data (pipe_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data_q  <= '0;
      oob_err_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      r_data_q  <= r_data_d;
      oob_err_q <= oob_err_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign mem.R_data = r_data_q;
  assign oob_err    = oob_err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances cover READ_LAT 1/2/3, a non-power-of-two
// depth, counter wrap, and reset with a read in flight.
module tb_ram_responder;
  import ram_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a;
  logic rstn_b;

  ram_intf bus0 ();
  ram_intf bus1 ();
  ram_intf bus2 ();

  logic        oob0, oob1, oob2;
  logic [31:0] rd0, wr0, rd2, wr2;
  logic [3:0]  rd1, wr1;

  ram_responder #(.DEPTH(100), .READ_LAT(1), .CNT_W(32)) u_lat1 (
    .clk(clk), .rstn(rstn_a), .mem(bus0), .oob_err(oob0), .rd_cnt(rd0), .wr_cnt(wr0)
  );
  ram_responder #(.DEPTH(4096), .READ_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rstn(rstn_a), .mem(bus1), .oob_err(oob1), .rd_cnt(rd1), .wr_cnt(wr1)
  );
  ram_responder #(.DEPTH(256), .READ_LAT(2), .CNT_W(32)) u_lat2 (
    .clk(clk), .rstn(rstn_b), .mem(bus2), .oob_err(oob2), .rd_cnt(rd2), .wr_cnt(wr2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic cs, input logic oe, input logic wreq,
                       input logic [ADDR_BUS_WIDTH-1:0] a, input logic [DATA_BUS_WIDTH-1:0] d);
    case (sel)
      0: begin bus0.cs = cs; bus0.oe = oe; bus0.W_req = wreq; bus0.addr = a; bus0.W_data = d; end
      1: begin bus1.cs = cs; bus1.oe = oe; bus1.W_req = wreq; bus1.addr = a; bus1.W_data = d; end
      default: begin bus2.cs = cs; bus2.oe = oe; bus2.W_req = wreq; bus2.addr = a; bus2.W_data = d; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input int sel, input logic [ADDR_BUS_WIDTH-1:0] a, input logic [DATA_BUS_WIDTH-1:0] d);
    drive(sel, 1'b1, 1'b0, 1'b1, a, d);
    step();
    idle(sel);
  endtask

  task automatic rd(input int sel, input logic [ADDR_BUS_WIDTH-1:0] a);
    drive(sel, 1'b1, 1'b1, 1'b0, a, '0);
    step();
    idle(sel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(0); idle(1); idle(2);
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    step(); step();
    check("rst_rdata0", 64'(bus0.R_data), 64'h0);
    check("rst_oob0",   64'(oob0), 64'h0);
    check("rst_rdcnt0", 64'(rd0), 64'h0);
    check("rst_wrcnt0", 64'(wr0), 64'h0);
    check("rst_rdata1", 64'(bus1.R_data), 64'h0);
    check("rst_rdata2", 64'(bus2.R_data), 64'h0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    step();

    // Basic write then read with READ_LAT=1
    wr(0, 16'd3, 32'hA5A5_0001);
    check("wr_cnt_1", 64'(wr0), 64'd1);
    rd(0, 16'd3);
    check("rd_cnt_1", 64'(rd0), 64'd1);
    check("lat1_not_early", 64'(bus0.R_data), 64'h0);
    step();
    check("lat1_rdata", 64'(bus0.R_data), 64'hA5A5_0001);

    // Write and read requested together: write wins
    drive(0, 1'b1, 1'b1, 1'b1, 16'd5, 32'h77);
    step();
    idle(0);
    check("both_wr_cnt", 64'(wr0), 64'd2);
    check("both_rd_cnt", 64'(rd0), 64'd1);
    step();
    check("both_rdata_hold", 64'(bus0.R_data), 64'hA5A5_0001);
    rd(0, 16'd5);
    step();
    check("both_addr5", 64'(bus0.R_data), 64'h77);
    check("rd_cnt_2", 64'(rd0), 64'd2);

    // oe low after a read must not disturb R_data
    wr(0, 16'd7, 32'h1234);
    rd(0, 16'd7);
    step();
    check("oe_rdata", 64'(bus0.R_data), 64'h1234);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 16'd7, '0);
      step();
      check("oe_low_hold", 64'(bus0.R_data), 64'h1234);
    end
    idle(0);
    check("oe_rd_cnt", 64'(rd0), 64'd3);
    check("oe_wr_cnt", 64'(wr0), 64'd3);

    // Out-of-range with DEPTH=100
    check("oob_clear", 64'(oob0), 64'h0);
    wr(0, 16'd120, 32'hDEAD_BEEF);
    check("oob_set_wr", 64'(oob0), 64'h1);
    check("oob_wr_cnt", 64'(wr0), 64'd4);
    rd(0, 16'd120);
    step();
    check("oob_rd_zero", 64'(bus0.R_data), 64'h0);
    check("oob_rd_cnt", 64'(rd0), 64'd4);
    wr(0, 16'd99, 32'h99);
    rd(0, 16'd99);
    step();
    check("last_addr", 64'(bus0.R_data), 64'h99);
    rd(0, 16'd100);
    step();
    check("first_oob_addr", 64'(bus0.R_data), 64'h0);
    rd(0, 16'd3);
    step();
    check("after_oob_rdata", 64'(bus0.R_data), 64'hA5A5_0001);
    check("oob_sticky", 64'(oob0), 64'h1);

    // READ_LAT=3 streaming reads, then 4-bit counter wrap
    for (int i = 0; i < 8; i++) begin
      wr(1, 16'(i), 32'(i * 16));
    end
    check("lat3_wr_cnt", 64'(wr1), 64'd8);
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1, 1'b1, 1'b1, 1'b0, 16'(k), '0);
      else idle(1);
      step();
      if (k >= 3) check("lat3_stream", 64'(bus1.R_data), 64'((k - 3) * 16));
      else check("lat3_not_early", 64'(bus1.R_data), 64'h0);
    end
    check("lat3_rd_cnt", 64'(rd1), 64'd8);
    for (int i = 8; i < 16; i++) begin
      wr(1, 16'(i), 32'h0);
    end
    check("wr_cnt_wrap", 64'(wr1), 64'd0);
    for (int i = 0; i < 8; i++) begin
      rd(1, 16'(i));
    end
    check("rd_cnt_wrap", 64'(rd1), 64'd0);
    check("lat3_no_oob", 64'(oob1), 64'h0);

    // READ_LAT=2: reset while a read is in flight
    wr(2, 16'd9, 32'hCAFE);
    rd(2, 16'd9);
    step();
    check("lat2_in_flight", 64'(bus2.R_data), 64'h0);
    rstn_b = 1'b0;
    #1;
    check("rst_flight_rdata", 64'(bus2.R_data), 64'h0);
    check("rst_flight_rdcnt", 64'(rd2), 64'd0);
    check("rst_flight_wrcnt", 64'(wr2), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_rdata", 64'(bus2.R_data), 64'h0);
    end
    rstn_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_stale", 64'(bus2.R_data), 64'h0);
    end
    rd(2, 16'd9);
    check("post_rst_rd_cnt", 64'(rd2), 64'd1);
    step();
    check("post_rst_lat2_early", 64'(bus2.R_data), 64'h0);
    step();
    check("post_rst_contents", 64'(bus2.R_data), 64'hCAFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the accelerator's `ram_intf` bus; it serves the `memory` modport from compute units such as the convolution engine and the weight/feature loaders. It holds a word-addressed on-chip storage array, executes writes, and returns read data through a fixed-latency pipeline. It also keeps sticky error status and access counters for bring-up and performance checks. One instance sits behind each buffer (input, weight, output) in the accelerator's buffer subsystem.

## Interface

Parameters:
- `DEPTH`, default 4096: number of words; legal addresses are 0..DEPTH-1.
- `READ_LAT`, default 1: cycles from read issue to `R_data` update; legal range 1..4.
- `CNT_W`, default 32: width of the access counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `mem`  modport  `ram_intf.memory`: `cs`, `oe`, `addr` [`ADDR_BUS_WIDTH`], `W_req`, `W_data` [`DATA_BUS_WIDTH`] in; `R_data` [`DATA_BUS_WIDTH`] out.
- `oob_err`  out  1: sticky flag, set on any out-of-range access.
- `rd_cnt`  out  CNT_W: count of accepted reads.
- `wr_cnt`  out  CNT_W: count of accepted writes.

## Operation

- Command decode, evaluated on every rising edge:
  - Write: `cs & W_req`.
  - Read: `cs & oe & ~W_req`.
  - Idle: `~cs`, or `cs & ~oe & ~W_req`.
- Simultaneous `W_req` and `oe`: the write wins and no read is issued.
- Write: `mem_array[addr] <= W_data` and `wr_cnt` increments.
- Read: the array is sampled at the issue edge. The value enters a READ_LAT-stage valid+data pipeline, and `rd_cnt` increments.
- Read/write ordering:
  - Read-before-write: a read and a write to the same address on the same edge cannot occur, because a write takes priority.
  - A write at edge t is visible to a read issued at edge t+1 or later.
- `R_data` is registered and updates only when a read exits the pipeline. Otherwise it holds its last value; it is never driven to X or zero between reads.
- Out of range (`addr >= DEPTH`, when DEPTH is not a power of two or the address bus is wider than needed):
  - The write is dropped.
  - The read is issued with data 0.
  - `oob_err` is set and stays set until reset.
  - The counters still increment.
- Back-to-back reads every cycle are fully pipelined, with one result per cycle.
- Counters wrap modulo 2^CNT_W.
- Array contents are not reset.

## Timing

- Reset (asynchronous assert, release synchronized by system):
  - `R_data` = 0, `oob_err` = 0, `rd_cnt` = 0, `wr_cnt` = 0.
  - All pipeline valid bits are 0.
- Reset during in-flight reads: results are discarded and never appear on `R_data`. Array contents are retained.
- Read latency: issue at edge t, `R_data` is valid after edge t+READ_LAT.
  - READ_LAT = 1: the classic synchronous SRAM timing expected by compute units.
- Write latency: the array is updated at edge t.
- No backpressure and no wait states: every command is accepted on the edge it is presented.
- `oe` low in later cycles does not cancel an already-issued read.

## Structure

- `ADDR_BUS_WIDTH` and `DATA_BUS_WIDTH` come from `conv_acc.svh`.
- Add `RAM_READ_LAT_MAX` = 4 to `conv_acc.svh`.
- Elaboration check: `1 <= READ_LAT <= RAM_READ_LAT_MAX`, and `DEPTH <= 2**ADDR_BUS_WIDTH`.
- Sub-module `ram_rd_pipe`: a parameterized valid+data shift pipeline with async active-low reset. The top level holds the decode logic, array, counters and error flag.
- The array is inferred as a plain register array. Technology SRAM macro substitution is done later behind the same ports.

## Test plan

- Reset, then write 0xA5A5_0001 to address 3, then read address 3 with READ_LAT=1 → `R_data` = 0xA5A5_0001 one edge after the read; `wr_cnt` = 1, `rd_cnt` = 1.
- READ_LAT=3: reads of addresses 0..7 on consecutive cycles after pre-loading data = addr*16 → `R_data` steps 0, 0x10, … 0x70, starting 3 edges after the first read, one value per cycle.
- `cs=1`, `oe=1`, `W_req=1` to address 5 with data 0x77 → address 5 holds 0x77, `R_data` is unchanged, `rd_cnt` is unchanged, `wr_cnt` increments.
- With DEPTH=100, write to address 120, then read address 120 → the write is dropped, the read returns 0, and `oob_err` = 1 and stays 1 through later valid accesses.
- Issue a read with READ_LAT=2, then assert `rstn`=0 one cycle later → `R_data` = 0 and stays 0 after release with no stale result. Contents written before reset read back intact.
- `oe` toggles low for 5 cycles after a read of 0x1234 → `R_data` holds 0x1234 throughout.
